button_nibble_entry: RTL and testbench
======================================

// Module: button_nibble_entry
// PURPOSE
//  Input counterpart of the LED nibble display. The user keys in a 16-bit value, MSB nibble first,
//  with two push buttons: INC steps the working nibble, NEXT commits it and moves to the next position.
//  After the 4th commit the value is presented on a valid/ready port to the consuming logic.
//  edit_sel/edit_nibble feed the display so the user sees the digit being edited.
// PARAMETERS
//  DEBOUNCE_CYCLES  120_000     cycles a synchronized button level must stay stable to be accepted (10 ms @ 12 MHz)
//  TIMEOUT_CYCLES   60_000_000  idle cycles in ENTRY before partial entry is discarded (5 s); 0 = disabled
// PORTS
//  clk          in   1   system clock (12 MHz)
//  rst_n        in   1   asynchronous active-low reset
//  btn_inc_n    in   1   raw INC button, active-low, asynchronous to clk
//  btn_next_n   in   1   raw NEXT button, active-low, asynchronous to clk
//  value        out  16  last completed entry; nibble 0 entered -> [15:12], nibble 3 -> [3:0]
//  value_valid  out  1   value is new and awaiting consumer
//  value_ready  in   1   consumer accepts value when value_valid && value_ready
//  edit_sel     out  2   position being edited (0 = MSB nibble)
//  edit_nibble  out  4   working digit at edit_sel
//  busy         out  1   high when entry is partially done (edit_sel != 0 or edit_nibble != 0) or in PRESENT
// BEHAVIOUR
//  Reset (async, rst_n low): value=0, value_valid=0, edit_sel=0, edit_nibble=0, busy=0, state=ENTRY,
//   shadow=0, all counters 0, synchronizer and debounced levels = released (1).
//  Input conditioning, per button:
//   - 2-flop synchronizer.
//   - Debounce counter clears whenever the synchronized level equals the debounced level.
//   - Otherwise it increments; when it reaches DEBOUNCE_CYCLES, the debounced level takes the
//     synchronized level and the counter clears.
//   - A press event is a 1-cycle pulse on the debounced 1->0 transition. Releases generate no event.
//   - A low level shorter than DEBOUNCE_CYCLES generates no event.
//  Press events are consumed in the cycle after the pulse. All outputs are registered.
//  FSM:
//   ENTRY:
//    - inc event: edit_nibble <= edit_nibble+1, modulo 16 (F->0).
//    - next event: shadow[15-4*edit_sel -: 4] <= edit_nibble and edit_nibble <= 0.
//      If edit_sel==3: value <= completed shadow, value_valid <= 1, edit_sel <= 0, state <= PRESENT.
//      Otherwise: edit_sel <= edit_sel+1.
//    - inc and next events in the same cycle: NEXT is processed; INC is dropped.
//    - Timeout counter clears on any event and increments otherwise while busy.
//      At TIMEOUT_CYCLES: shadow, edit_sel and edit_nibble clear, and no valid is produced.
//      Counter is held at 0 when !busy or TIMEOUT_CYCLES==0.
//   PRESENT:
//    - value and value_valid are held stable. All button events are ignored. No timeout.
//    - On value_valid && value_ready: value_valid <= 0 on the next edge, shadow <= 0, state <= ENTRY.
//  value keeps its last completed contents after the handshake until the next completion.
//  value_valid never drops without a handshake; value_ready while !value_valid has no effect.
//  Debouncing continues in PRESENT, so a button held across the handshake produces no extra event.
// TESTING  (bench params: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100)
//  1. Clean presses: INC x1, NEXT, INC x10, NEXT, INC x3, NEXT, NEXT -> value=16'h1A30,
//     value_valid=1, edit_sel=0.
//  2. Bounce: btn_inc_n low 3 cycles then high -> no edit_nibble change. Low 6 cycles with
//     1-cycle highs inside before settling low -> exactly one increment.
//  3. Wrap: 17 INC presses at edit_sel=0 -> edit_nibble=1. Simultaneous INC+NEXT event ->
//     nibble committed, edit_nibble=0.
//  4. Back-pressure: complete 16'hBEEF with value_ready=0 for 50 cycles while pressing INC/NEXT ->
//     value/valid stable, edit outputs unchanged. value_ready=1 -> valid low the next cycle,
//     back in ENTRY.
//  5. Timeout: enter 2 nibbles, idle 100 cycles -> edit_sel=0, edit_nibble=0, busy=0, no valid.
//     Repeat at 99 idle cycles then INC -> entry preserved.
//  6. Reset mid-entry and during PRESENT -> all outputs 0 immediately (async), and the next
//     entry starts at edit_sel=0.

Source files
------------

// File: rtl/button_nibble_entry_if.sv
// Completed-value handshake between the nibble entry block and its consumer.
// The producer holds value/value_valid stable until value_ready is seen.
interface button_nibble_entry_if;
    logic [15:0] value;
    logic        value_valid;
    logic        value_ready;

    modport master (output value, output value_valid, input value_ready);
    modport slave  (input value, input value_valid, output value_ready);
endinterface

// File: rtl/button_nibble_entry.sv
// Two-button 16-bit value entry: INC steps the working nibble, NEXT commits it (MSB first).
// The completed value is offered on a valid/ready port; edit outputs drive the nibble display.
module button_nibble_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 120_000,
    parameter int unsigned TIMEOUT_CYCLES  = 60_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_btn_inc_n,
    input  logic                          i_btn_next_n,
    button_nibble_entry_if.master         o_value_if,
    output logic [1:0]                    o_edit_sel,
    output logic [3:0]                    o_edit_nibble,
    output logic                          o_busy
);
    localparam int unsigned DW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_EN ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic {ST_ENTRY = 1'b0, ST_PRESENT = 1'b1} state_t;

    // Index 0 = INC, index 1 = NEXT.
    logic [1:0]    w_btn_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_deb;
    logic [1:0]    r_evt;
    logic [DW-1:0] r_deb_cnt [2];

    state_t        r_state;
    state_t        w_state_nxt;
    logic [11:0]   r_shadow;
    logic [1:0]    r_edit_sel;
    logic [3:0]    r_edit_nibble;
    logic [15:0]   r_value;
    logic          r_valid;
    logic          r_busy;
    logic [TW-1:0] r_tmo_cnt;

    logic [11:0]   w_shadow_nxt;
    logic [1:0]    w_sel_nxt;
    logic [3:0]    w_nib_nxt;
    logic [15:0]   w_value_nxt;
    logic          w_valid_nxt;
    logic [TW-1:0] w_tmo_nxt;
    logic          w_inc_evt;
    logic          w_next_evt;
    logic          w_partial;
    logic          w_handshake;

    assign w_btn_raw   = {i_btn_next_n, i_btn_inc_n};
    assign w_next_evt  = r_evt[1];
    assign w_inc_evt   = r_evt[0] & ~r_evt[1];
    assign w_partial   = (r_edit_sel != 2'd0) || (r_edit_nibble != 4'd0);
    assign w_handshake = r_valid & o_value_if.value_ready;

    // Synchronize, debounce and edge-detect both buttons; a press is a 1-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 2'b11;
            r_sync2 <= 2'b11;
            r_deb   <= 2'b11;
            r_evt   <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                r_deb_cnt[b] <= '0;
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int b = 0; b < 2; b++) begin
                r_evt[b] <= 1'b0;
                if (r_sync2[b] == r_deb[b]) begin
                    r_deb_cnt[b] <= '0;
                end else if (r_deb_cnt[b] == DEB_LAST) begin
                    r_deb[b]     <= r_sync2[b];
                    r_deb_cnt[b] <= '0;
                    r_evt[b]     <= ~r_sync2[b];
                end else begin
                    r_deb_cnt[b] <= r_deb_cnt[b] + DW'(1);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ENTRY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: the fourth commit presents the value, the handshake returns to entry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ENTRY: begin
                if (w_next_evt && (r_edit_sel == 2'd3)) begin
                    w_state_nxt = ST_PRESENT;
                end else begin
                    w_state_nxt = ST_ENTRY;
                end
            end
            ST_PRESENT: begin
                if (w_handshake) begin
                    w_state_nxt = ST_ENTRY;
                end else begin
                    w_state_nxt = ST_PRESENT;
                end
            end
            default: w_state_nxt = ST_ENTRY;
        endcase
    end

    // Output/datapath next values: edit, commit, timeout and handshake effects.
    always_comb begin
        w_shadow_nxt = r_shadow;
        w_sel_nxt    = r_edit_sel;
        w_nib_nxt    = r_edit_nibble;
        w_value_nxt  = r_value;
        w_valid_nxt  = r_valid;
        w_tmo_nxt    = '0;
        case (r_state)
            ST_ENTRY: begin
                if (w_next_evt) begin
                    case (r_edit_sel)
                        2'd0:    w_shadow_nxt[11:8] = r_edit_nibble;
                        2'd1:    w_shadow_nxt[7:4]  = r_edit_nibble;
                        2'd2:    w_shadow_nxt[3:0]  = r_edit_nibble;
                        default: w_shadow_nxt       = r_shadow;
                    endcase
                    w_nib_nxt = 4'd0;
                    if (r_edit_sel == 2'd3) begin
                        w_value_nxt = {r_shadow, r_edit_nibble};
                        w_valid_nxt = 1'b1;
                        w_sel_nxt   = 2'd0;
                    end else begin
                        w_sel_nxt = r_edit_sel + 2'd1;
                    end
                end else if (w_inc_evt) begin
                    w_nib_nxt = r_edit_nibble + 4'd1;
                end else if (!w_partial || !TMO_EN) begin
                    w_tmo_nxt = '0;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_shadow_nxt = 12'd0;
                    w_sel_nxt    = 2'd0;
                    w_nib_nxt    = 4'd0;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + TW'(1);
                end
            end
            ST_PRESENT: begin
                if (w_handshake) begin
                    w_valid_nxt  = 1'b0;
                    w_shadow_nxt = 12'd0;
                end else begin
                    w_valid_nxt = r_valid;
                end
            end
            default: begin
                w_valid_nxt = r_valid;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow      <= 12'd0;
            r_edit_sel    <= 2'd0;
            r_edit_nibble <= 4'd0;
            r_value       <= 16'd0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
            r_tmo_cnt     <= '0;
        end else begin
            r_shadow      <= w_shadow_nxt;
            r_edit_sel    <= w_sel_nxt;
            r_edit_nibble <= w_nib_nxt;
            r_value       <= w_value_nxt;
            r_valid       <= w_valid_nxt;
            r_busy        <= (w_state_nxt == ST_PRESENT) || (w_sel_nxt != 2'd0) || (w_nib_nxt != 4'd0);
            r_tmo_cnt     <= w_tmo_nxt;
        end
    end

    assign o_value_if.value       = r_value;
    assign o_value_if.value_valid = r_valid;
    assign o_edit_sel             = r_edit_sel;
    assign o_edit_nibble          = r_edit_nibble;
    assign o_busy                 = r_busy;
endmodule

// File: tb/tb_button_nibble_entry.sv
// Bench for button_nibble_entry: directed scenarios plus random button/ready traffic,
// compared every cycle against a behavioural model of the entry procedure.
module tb_button_nibble_entry;
    localparam int D = 4;
    localparam int T = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_inc_n = 1'b1;
    logic       btn_next_n = 1'b1;
    logic [1:0] edit_sel;
    logic [3:0] edit_nibble;
    logic       busy;

    int checks = 0;
    int errors = 0;

    button_nibble_entry_if vif ();

    button_nibble_entry #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_btn_inc_n   (btn_inc_n),
        .i_btn_next_n  (btn_next_n),
        .o_value_if    (vif),
        .o_edit_sel    (edit_sel),
        .o_edit_nibble (edit_nibble),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: digits typed so far, cursor, working digit, presented value.
    logic [3:0]  m_digit [4];
    logic [1:0]  m_pos;
    logic [3:0]  m_work;
    logic [15:0] m_value;
    logic        m_valid;
    logic        m_present;
    int          m_idle;
    logic [15:0] m_hist [2];
    logic [1:0]  m_deb;
    logic [1:0]  m_pend;
    logic        m_busy;

    assign m_busy = m_present || (m_pos != 2'd0) || (m_work != 4'd0);

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_digit[i] = 4'd0;
        m_pos = 2'd0; m_work = 4'd0; m_value = 16'd0; m_valid = 1'b0;
        m_present = 1'b0; m_idle = 0; m_deb = 2'b11; m_pend = 2'b00;
        m_hist[0] = 16'hFFFF; m_hist[1] = 16'hFFFF;
    endtask

    task automatic model_step();
        logic [1:0] raws;
        logic       differ;
        if (!m_present) begin
            if (m_pend[1]) begin
                m_digit[m_pos] = m_work;
                m_work = 4'd0;
                m_idle = 0;
                if (m_pos == 2'd3) begin
                    m_value   = {m_digit[0], m_digit[1], m_digit[2], m_digit[3]};
                    m_valid   = 1'b1;
                    m_present = 1'b1;
                    m_pos     = 2'd0;
                end else begin
                    m_pos = m_pos + 2'd1;
                end
            end else if (m_pend[0]) begin
                m_work = m_work + 4'd1;
                m_idle = 0;
            end else if (m_pos != 2'd0 || m_work != 4'd0) begin
                m_idle++;
                if (m_idle == T) begin
                    for (int i = 0; i < 4; i++) m_digit[i] = 4'd0;
                    m_pos = 2'd0; m_work = 4'd0; m_idle = 0;
                end
            end else begin
                m_idle = 0;
            end
        end else if (m_valid && vif.value_ready) begin
            m_valid = 1'b0;
            m_present = 1'b0;
            for (int i = 0; i < 4; i++) m_digit[i] = 4'd0;
        end
        // A button level counts once the synchronized input has differed from it for D samples.
        raws = {btn_next_n, btn_inc_n};
        for (int b = 0; b < 2; b++) begin
            m_hist[b] = {m_hist[b][14:0], raws[b]};
            differ = 1'b1;
            for (int i = 0; i < D; i++) begin
                if (m_hist[b][2 + i] == m_deb[b]) differ = 1'b0;
            end
            m_pend[b] = 1'b0;
            if (differ) begin
                m_pend[b] = m_deb[b];
                m_deb[b]  = ~m_deb[b];
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ({vif.value, vif.value_valid, edit_sel, edit_nibble, busy} !==
                {m_value, m_valid, m_pos, m_work, m_busy}) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got value=%h valid=%b sel=%0d nib=%h busy=%b, want value=%h valid=%b sel=%0d nib=%h busy=%b",
                         $time, vif.value, vif.value_valid, edit_sel, edit_nibble, busy,
                         m_value, m_valid, m_pos, m_work, m_busy);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // which: 0 = INC, 1 = NEXT, 2 = both together.
    task automatic press(input int which);
        if (which != 1) btn_inc_n = 1'b0;
        if (which != 0) btn_next_n = 1'b0;
        tick(8);
        btn_inc_n = 1'b1;
        btn_next_n = 1'b1;
        tick(8);
    endtask

    task automatic press_n(input int which, input int n);
        for (int i = 0; i < n; i++) press(which);
    endtask

    task automatic inc_pattern(input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            btn_inc_n = pat[i];
            tick(1);
        end
        btn_inc_n = 1'b1;
        tick(8);
    endtask

    task automatic check_zero(input string name);
        check_lit(name, {8'd0, vif.value, vif.value_valid, edit_sel, edit_nibble, busy}, 32'd0);
    endtask

    task automatic async_reset();
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("reset_async_outputs");
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic handshake();
        vif.value_ready = 1'b1;
        tick(1);
        check_lit("handshake_valid_drop", {31'd0, vif.value_valid}, 32'd0);
        vif.value_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] glitch_pat;
        vif.value_ready = 1'b0;
        #1;
        check_zero("reset_state");
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // Clean presses -> 1A30.
        press(0); press(1);
        press_n(0, 10); press(1);
        press_n(0, 3); press(1);
        press(1);
        check_lit("s1_value", {16'd0, vif.value}, 32'h1A30);
        check_lit("s1_valid", {31'd0, vif.value_valid}, 32'd1);
        check_lit("s1_edit_sel", {30'd0, edit_sel}, 32'd0);
        check_lit("s1_model_value", {16'd0, m_value}, 32'h1A30);
        handshake();
        check_lit("s1_busy_after_hs", {31'd0, busy}, 32'd0);

        // Bounce: short low ignored, glitchy low gives one increment.
        inc_pattern(16'h0000, 3);
        check_lit("s2_short_low", {28'd0, edit_nibble}, 32'd0);
        glitch_pat = 16'b0000_0000_0001_0010;
        inc_pattern(glitch_pat, 12);
        check_lit("s2_glitch_one_inc", {28'd0, edit_nibble}, 32'd1);

        // Wrap and simultaneous INC+NEXT.
        async_reset();
        press_n(0, 17);
        check_lit("s3_wrap", {28'd0, edit_nibble}, 32'd1);
        press(2);
        check_lit("s3_both_sel", {30'd0, edit_sel}, 32'd1);
        check_lit("s3_both_nib", {28'd0, edit_nibble}, 32'd0);
        press_n(1, 3);
        check_lit("s3_value", {16'd0, vif.value}, 32'h1000);
        handshake();

        // Back-pressure on BEEF.
        press_n(0, 11); press(1);
        press_n(0, 14); press(1);
        press_n(0, 14); press(1);
        press_n(0, 15); press(1);
        press(0); press(1); press(2);
        check_lit("s4_value_held", {16'd0, vif.value}, 32'hBEEF);
        check_lit("s4_valid_held", {31'd0, vif.value_valid}, 32'd1);
        check_lit("s4_edit_held", {26'd0, edit_sel, edit_nibble}, 32'd0);
        handshake();
        press(0);
        check_lit("s4_back_in_entry", {26'd0, edit_sel, edit_nibble}, 32'h01);

        // Timeout at exactly T idle cycles, and survival at T-1.
        async_reset();
        press(0); press(1); press_n(0, 2); press(1);
        tick(91);
        check_zero("s5_timeout_clear");
        press(0); press(1); press(1);
        tick(84);
        press(0);
        check_lit("s5_just_in_time", {26'd0, edit_sel, edit_nibble}, 32'h21);

        // Reset mid-entry and during PRESENT.
        async_reset();
        press(0); press(1); press(0);
        async_reset();
        press(0);
        check_lit("s6_restart_entry", {26'd0, edit_sel, edit_nibble}, 32'h01);
        press_n(1, 4);
        check_lit("s6_present_valid", {31'd0, vif.value_valid}, 32'd1);
        async_reset();
        press(0);
        check_lit("s6_after_present_reset", {26'd0, edit_sel, edit_nibble}, 32'h01);

        // Random traffic: bouncy bursts, long idles, random ready.
        for (int it = 0; it < 150; it++) begin
            vif.value_ready = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) < 7) begin
                for (int c = 0; c < $urandom_range(1, 10); c++) begin
                    btn_inc_n  = ($urandom_range(0, 3) == 0);
                    btn_next_n = ($urandom_range(0, 4) != 0);
                    tick(1);
                end
                btn_inc_n = 1'b1;
                btn_next_n = 1'b1;
                tick($urandom_range(0, 8));
            end else begin
                tick($urandom_range(20, 110));
            end
        end
        vif.value_ready = 1'b0;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
